connect4_move_controller: RTL and testbench

- Sequences one Connect4 move at a time on the 4x4 board: decodes the active-low column buttons, tracks per-column fill height, and issues a single-cycle cell write with a linear address.
- Alternates players, waits for the external win checker's verdict after each write, and declares a win, a draw or continued play.
- Sits between the debounced button inputs and the board memory / win checker.

---
 rtl/connect4_pkg.sv | 38 +++
 rtl/column_height_tracker.sv | 43 ++++
 rtl/connect4_move_controller.sv | 216 +++++++++++++++++++++
 tb/tb_connect4_move_controller.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared constants and types for the Connect4 move controller.
// Holds the board geometry, the "no cell" address sentinel, the controller
// state encoding, the winner encoding and a helper that builds a linear cell
// address. Optional feature macro used by the controller: TURN_TIMEOUT_EN.
package connect4_pkg;

  localparam int unsigned COLS  = 4;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned POS_W = 5;
  localparam int unsigned CELLS = ROWS * COLS;
  // Height must represent 0..ROWS inclusive.
  localparam int unsigned HGT_W = $clog2(ROWS + 1);
  localparam int unsigned COL_W = $clog2(COLS);

  localparam logic [POS_W-1:0] INVALID_POS = 5'b11111;

  typedef enum logic [2:0] {
    WAIT_PRESS,
    WRITE,
    CHECK,
    WAIT_RELEASE,
    GAME_OVER
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    DRAW = 2'b11
  } winner_e;

  // Linear address of the cell at row h in column c: h*COLS + c.
  function automatic logic [POS_W-1:0] cell_pos(input logic [HGT_W-1:0] h,
                                                input logic [COL_W-1:0] c);
    return POS_W'((32'(h) * COLS) + 32'(c));
  endfunction

endpackage

// File: rtl/column_height_tracker.sv
// Per-column fill-height counters for the Connect4 board.
// Ports:
//   i_clk, i_reset  clock and asynchronous active-high reset
//   i_clear         synchronous clear of all heights
//   i_inc           increment strobe for column i_inc_col
//   i_inc_col       column index to increment
//   o_heights       current height of every column (0..ROWS)
//   o_column_full   bit c high when column c holds ROWS pieces
module column_height_tracker
  import connect4_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clear,
  input  logic                        i_inc,
  input  logic [COL_W-1:0]            i_inc_col,
  output logic [COLS-1:0][HGT_W-1:0]  o_heights,
  output logic [COLS-1:0]             o_column_full
);

  logic [COLS-1:0][HGT_W-1:0] r_height;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_height <= '0;
    end else if (i_clear) begin
      r_height <= '0;
    end else if (i_inc && (r_height[i_inc_col] != HGT_W'(ROWS))) begin
      // Saturate at ROWS so a stray strobe can never wrap a full column.
      r_height[i_inc_col] <= r_height[i_inc_col] + 1'b1;
    end
  end

  always_comb begin
    o_column_full = '0;
    for (int c = 0; c < COLS; c++) begin
      o_column_full[c] = (r_height[c] == HGT_W'(ROWS));
    end
  end

  assign o_heights = r_height;

endmodule

// File: rtl/connect4_move_controller.sv
// Connect4 move sequencer for a 4x4 board.
// Decodes active-low one-hot column buttons, issues one single-cycle cell write
// per accepted move, waits for the external win checker verdict and declares
// win, draw or continued play, alternating players between moves.
// Optional feature: define TURN_TIMEOUT_EN to forfeit a turn after
// TIMEOUT_CYCLES idle cycles in WAIT_PRESS (turn_timeout tied 0 otherwise).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   btn_n               column buttons, active-low, one-hot-low
//   new_game            synchronous restart, priority over everything
//   win_valid           win checker verdict valid this cycle
//   win_detected        last piece completes four in a row (with win_valid)
//   cell_we             board write strobe, one cycle per move
//   cell_addr           row*COLS+col while writing, INVALID_POS otherwise
//   cell_player         owner of the written piece
//   cur_player          player whose turn it is
//   column_full         per-column full flags
//   illegal_move        one-cycle pulse on a press into a full column
//   game_over           high in GAME_OVER
//   winner              00 none, 01 P1, 10 P2, 11 draw
//   turn_timeout        one-cycle pulse on a forfeited turn
module connect4_move_controller
  import connect4_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COLS-1:0]   btn_n,
  input  logic              new_game,
  input  logic              win_valid,
  input  logic              win_detected,
  output logic              cell_we,
  output logic [POS_W-1:0]  cell_addr,
  output logic              cell_player,
  output logic              cur_player,
  output logic [COLS-1:0]   column_full,
  output logic              illegal_move,
  output logic              game_over,
  output logic [1:0]        winner,
  output logic              turn_timeout
);

  state_e                      r_state;
  state_e                      w_state_next;
  logic                        r_cur_player;
  logic                        r_cell_player;
  logic [POS_W-1:0]            r_addr;
  logic [COL_W-1:0]            r_col;
  logic [POS_W-1:0]            r_move_cnt;
  winner_e                     r_winner;
  logic                        r_illegal;
  logic [COLS-1:0][HGT_W-1:0]  w_heights;
  logic [COLS-1:0]             w_btn_low;
  logic                        w_single;
  logic [COL_W-1:0]            w_sel_col;
  logic                        w_sel_full;
  logic                        w_timeout_hit;

  // Button decode: exactly one low bit selects a column.
  assign w_btn_low = ~btn_n;
  assign w_single  = (w_btn_low != '0) && ((w_btn_low & (w_btn_low - 1'b1)) == '0);

  always_comb begin
    w_sel_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (w_btn_low[c]) w_sel_col = COL_W'(c);
    end
  end

  assign w_sel_full = column_full[w_sel_col];

  column_height_tracker u_heights (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_clear       (new_game),
    .i_inc         (cell_we),
    .i_inc_col     (r_col),
    .o_heights     (w_heights),
    .o_column_full (column_full)
  );

`ifdef TURN_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_turn_timeout;

  assign w_timeout_hit = (r_state == WAIT_PRESS) && !w_single &&
                         (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt       <= '0;
      r_turn_timeout <= 1'b0;
    end else if (new_game) begin
      r_to_cnt       <= '0;
      r_turn_timeout <= 1'b0;
    end else begin
      r_turn_timeout <= w_timeout_hit;
      if ((r_state != WAIT_PRESS) || w_single || w_timeout_hit) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign turn_timeout = r_turn_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout_hit    = 1'b0;
  assign turn_timeout     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_PRESS;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    if (new_game) begin
      w_state_next = WAIT_PRESS;
    end else begin
      case (r_state)
        WAIT_PRESS: begin
          if (w_single) w_state_next = w_sel_full ? WAIT_RELEASE : WRITE;
        end
        WRITE: w_state_next = CHECK;
        CHECK: begin
          if (win_valid) begin
            if (win_detected || (r_move_cnt == POS_W'(CELLS))) begin
              w_state_next = GAME_OVER;
            end else begin
              w_state_next = WAIT_RELEASE;
            end
          end
        end
        WAIT_RELEASE: begin
          if (btn_n == '1) w_state_next = WAIT_PRESS;
        end
        GAME_OVER: w_state_next = GAME_OVER;
        default:   w_state_next = WAIT_PRESS;
      endcase
    end
  end

  // Move datapath: latched address/player, move count, turn and verdict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_player  <= 1'b0;
      r_cell_player <= 1'b0;
      r_addr        <= INVALID_POS;
      r_col         <= '0;
      r_move_cnt    <= '0;
      r_winner      <= NONE;
      r_illegal     <= 1'b0;
    end else if (new_game) begin
      r_cur_player  <= 1'b0;
      r_cell_player <= 1'b0;
      r_addr        <= INVALID_POS;
      r_col         <= '0;
      r_move_cnt    <= '0;
      r_winner      <= NONE;
      r_illegal     <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        WAIT_PRESS: begin
          if (w_single) begin
            if (w_sel_full) begin
              r_illegal <= 1'b1;
            end else begin
              r_addr        <= cell_pos(w_heights[w_sel_col], w_sel_col);
              r_cell_player <= r_cur_player;
              r_col         <= w_sel_col;
            end
          end else if (w_timeout_hit) begin
            r_cur_player <= ~r_cur_player;
          end
        end
        WRITE: r_move_cnt <= r_move_cnt + 1'b1;
        CHECK: begin
          if (win_valid) begin
            if (win_detected) begin
              r_winner <= r_cur_player ? P2 : P1;
            end else if (r_move_cnt == POS_W'(CELLS)) begin
              r_winner <= DRAW;
            end else begin
              r_cur_player <= ~r_cur_player;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs; a new_game coinciding with WRITE cancels the write.
  always_comb begin
    cell_we   = (r_state == WRITE) && !new_game;
    cell_addr = cell_we ? r_addr : INVALID_POS;
    game_over = (r_state == GAME_OVER);
  end

  assign cell_player  = r_cell_player;
  assign cur_player   = r_cur_player;
  assign illegal_move = r_illegal;
  assign winner       = r_winner;

endmodule

// File: tb/tb_connect4_move_controller.sv
module tb_connect4_move_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_n = 4'hF;
  logic       new_game = 1'b0;
  logic       win_valid = 1'b0;
  logic       win_detected = 1'b0;
  logic       cell_we;
  logic [4:0] cell_addr;
  logic       cell_player;
  logic       cur_player;
  logic [3:0] column_full;
  logic       illegal_move;
  logic       game_over;
  logic [1:0] winner;
  logic       turn_timeout;

  int checks = 0;
  int failures = 0;

  localparam logic [16:0] RESET_VEC = {1'b0, 5'h1F, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0};

  connect4_move_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_n        (btn_n),
    .new_game     (new_game),
    .win_valid    (win_valid),
    .win_detected (win_detected),
    .cell_we      (cell_we),
    .cell_addr    (cell_addr),
    .cell_player  (cell_player),
    .cur_player   (cur_player),
    .column_full  (column_full),
    .illegal_move (illegal_move),
    .game_over    (game_over),
    .winner       (winner),
    .turn_timeout (turn_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic logic [16:0] out_vec();
    return {cell_we, cell_addr, cell_player, cur_player, column_full, illegal_move,
            game_over, winner, turn_timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    btn_n = 4'hF; new_game = 1'b0; win_valid = 1'b0; win_detected = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Press a column, watch for the write (bounded), answer the checker, hold, release.
  task automatic do_move(input int col, input int hold, input logic win, output logic seen,
                         output logic [4:0] addr, output logic plr, output logic ill,
                         output int extra);
    seen = 1'b0; addr = 5'h1F; plr = 1'b0; ill = 1'b0; extra = 0;
    btn_n = 4'hF;
    btn_n[col] = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (cell_we) begin seen = 1'b1; addr = cell_addr; plr = cell_player; end
      if (illegal_move) ill = 1'b1;
    end
    if (seen) begin
      tick();
      win_valid = 1'b1; win_detected = win;
      tick();
      win_valid = 1'b0; win_detected = 1'b0;
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      if (cell_we) extra++;
    end
    btn_n = 4'hF;
    tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h", out_vec(), RESET_VEC);
    end
    apply_reset();
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL post_reset_outputs got=%h want=%h", out_vec(), RESET_VEC);
    end
  endtask

  task automatic test_first_move();
    logic seen, plr, ill; logic [4:0] addr; int extra;
    apply_reset();
    do_move(0, 3, 1'b0, seen, addr, plr, ill, extra);
    checks++;
    if (seen !== 1'b1 || addr !== 5'd0 || plr !== 1'b0) begin
      failures++;
      $display("FAIL first_move got we=%b addr=%0d plr=%b want we=1 addr=0 plr=0",
               seen, addr, plr);
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL held_button_extra_writes got=%0d want=0", extra);
    end
    checks++;
    if (cur_player !== 1'b1) begin
      failures++;
      $display("FAIL first_move_toggle cur_player got=%b want=1", cur_player);
    end
  endtask

  task automatic test_column_fill();
    logic seen, plr, ill; logic [4:0] addr; int extra;
    logic [4:0] exp_addr;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      do_move(1, 0, 1'b0, seen, addr, plr, ill, extra);
      exp_addr = 5'(k * 4 + 1);
      checks++;
      if (seen !== 1'b1 || addr !== exp_addr || plr !== 1'(k % 2)) begin
        failures++;
        $display("FAIL col1_move%0d got we=%b addr=%0d plr=%b want we=1 addr=%0d plr=%0d",
                 k, seen, addr, plr, exp_addr, k % 2);
      end
    end
    checks++;
    if (column_full !== 4'b0010) begin
      failures++;
      $display("FAIL column_full got=%b want=0010", column_full);
    end
    do_move(1, 0, 1'b0, seen, addr, plr, ill, extra);
    checks++;
    if (seen !== 1'b0 || ill !== 1'b1) begin
      failures++;
      $display("FAIL full_column_press got we=%b illegal=%b want we=0 illegal=1", seen, ill);
    end
    checks++;
    if (cur_player !== 1'b0 || illegal_move !== 1'b0) begin
      failures++;
      $display("FAIL after_illegal got cur=%b illegal=%b want cur=0 illegal=0",
               cur_player, illegal_move);
    end
  endtask

  task automatic test_ignored_patterns();
    logic seen, plr, ill; logic [4:0] addr; int extra;
    int we_cnt, ill_cnt;
    apply_reset();
    we_cnt = 0; ill_cnt = 0;
    btn_n = 4'b1100;
    for (int i = 0; i < 10; i++) begin
      tick(); if (cell_we) we_cnt++; if (illegal_move) ill_cnt++;
    end
    btn_n = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick(); if (cell_we) we_cnt++; if (illegal_move) ill_cnt++;
    end
    checks++;
    if (we_cnt !== 0 || ill_cnt !== 0) begin
      failures++;
      $display("FAIL ignored_patterns got we=%0d illegal=%0d want 0 0", we_cnt, ill_cnt);
    end
    do_move(2, 0, 1'b0, seen, addr, plr, ill, extra);
    checks++;
    if (seen !== 1'b1 || addr !== 5'd2 || plr !== 1'b0) begin
      failures++;
      $display("FAIL press_after_ignored got we=%b addr=%0d plr=%b want 1 2 0", seen, addr, plr);
    end
  endtask

  task automatic test_win();
    logic seen, plr, ill; logic [4:0] addr; int extra;
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      do_move(k % 2, 0, (k == 6), seen, addr, plr, ill, extra);
    end
    checks++;
    if (addr !== 5'd12 || plr !== 1'b0) begin
      failures++;
      $display("FAIL win_last_write got addr=%0d plr=%b want addr=12 plr=0", addr, plr);
    end
    checks++;
    if (game_over !== 1'b1 || winner !== 2'b01) begin
      failures++;
      $display("FAIL win_verdict got over=%b winner=%b want over=1 winner=01", game_over, winner);
    end
    do_move(2, 0, 1'b0, seen, addr, plr, ill, extra);
    checks++;
    if (seen !== 1'b0 || game_over !== 1'b1 || winner !== 2'b01) begin
      failures++;
      $display("FAIL press_in_game_over got we=%b over=%b winner=%b want 0 1 01",
               seen, game_over, winner);
    end
  endtask

  task automatic fill_board(input logic last_win);
    logic seen, plr, ill; logic [4:0] addr; int extra;
    logic [4:0] exp_addr;
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      do_move(k / 4, 0, last_win && (k == 15), seen, addr, plr, ill, extra);
      exp_addr = 5'((k % 4) * 4 + (k / 4));
      checks++;
      if (seen !== 1'b1 || addr !== exp_addr || plr !== 1'(k % 2)) begin
        failures++;
        $display("FAIL fill_move%0d got we=%b addr=%0d plr=%b want we=1 addr=%0d plr=%0d",
                 k, seen, addr, plr, exp_addr, k % 2);
      end
      if (k == 14) begin
        checks++;
        if (game_over !== 1'b0 || winner !== 2'b00) begin
          failures++;
          $display("FAIL move15_continue got over=%b winner=%b want 0 00", game_over, winner);
        end
      end
    end
  endtask

  task automatic test_draw_and_new_game();
    logic seen, plr, ill; logic [4:0] addr; int extra;
    fill_board(1'b0);
    checks++;
    if (game_over !== 1'b1 || winner !== 2'b11 || column_full !== 4'hF) begin
      failures++;
      $display("FAIL draw got over=%b winner=%b full=%b want 1 11 1111",
               game_over, winner, column_full);
    end
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL new_game_restore got=%h want=%h", out_vec(), RESET_VEC);
    end
    do_move(0, 0, 1'b0, seen, addr, plr, ill, extra);
    checks++;
    if (seen !== 1'b1 || addr !== 5'd0 || plr !== 1'b0) begin
      failures++;
      $display("FAIL press_after_new_game got we=%b addr=%0d plr=%b want 1 0 0", seen, addr, plr);
    end
  endtask

  task automatic test_win_on_last_move();
    fill_board(1'b1);
    checks++;
    if (game_over !== 1'b1 || winner !== 2'b10) begin
      failures++;
      $display("FAIL win_on_16th got over=%b winner=%b want 1 10", game_over, winner);
    end
  endtask

  task automatic test_new_game_in_write();
    logic seen, plr, ill; logic [4:0] addr; int extra;
    apply_reset();
    btn_n = 4'b0111;
    tick();
    new_game = 1'b1;
    #1;
    checks++;
    if (cell_we !== 1'b0 || cell_addr !== 5'h1F) begin
      failures++;
      $display("FAIL write_suppressed got we=%b addr=%0d want we=0 addr=31", cell_we, cell_addr);
    end
    tick();
    new_game = 1'b0;
    btn_n = 4'hF;
    tick();
    do_move(3, 0, 1'b0, seen, addr, plr, ill, extra);
    checks++;
    if (seen !== 1'b1 || addr !== 5'd3 || plr !== 1'b0) begin
      failures++;
      $display("FAIL move_after_cancel got we=%b addr=%0d plr=%b want 1 3 0", seen, addr, plr);
    end
  endtask

  task automatic test_async_reset_in_check();
    logic seen, plr, ill; logic [4:0] addr; int extra;
    apply_reset();
    do_move(2, 0, 1'b0, seen, addr, plr, ill, extra);
    btn_n = 4'b1011;
    tick();
    checks++;
    if (cell_we !== 1'b1 || cell_addr !== 5'd6 || cell_player !== 1'b1) begin
      failures++;
      $display("FAIL second_write got we=%b addr=%0d plr=%b want 1 6 1",
               cell_we, cell_addr, cell_player);
    end
    btn_n = 4'hF;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL async_reset_in_check got=%h want=%h", out_vec(), RESET_VEC);
    end
    tick();
    reset = 1'b0;
    tick();
    do_move(2, 0, 1'b0, seen, addr, plr, ill, extra);
    checks++;
    if (seen !== 1'b1 || addr !== 5'd2 || plr !== 1'b0) begin
      failures++;
      $display("FAIL move_after_async_reset got we=%b addr=%0d plr=%b want 1 2 0",
               seen, addr, plr);
    end
  endtask

  task automatic test_turn_timeout();
    int pulse_cycle, pulses, we_cnt;
    apply_reset();
    pulse_cycle = -1; pulses = 0; we_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (turn_timeout) begin
        pulses++;
        if (pulse_cycle < 0) pulse_cycle = i;
      end
      if (cell_we) we_cnt++;
    end
`ifdef TURN_TIMEOUT_EN
    checks++;
    if (pulse_cycle !== 8 || pulses !== 1 || we_cnt !== 0 || cur_player !== 1'b1) begin
      failures++;
      $display("FAIL turn_timeout got cycle=%0d pulses=%0d we=%0d cur=%b want 8 1 0 1",
               pulse_cycle, pulses, we_cnt, cur_player);
    end
`else
    checks++;
    if (pulses !== 0 || we_cnt !== 0 || cur_player !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_timeout got pulses=%0d we=%0d cur=%b want 0 0 0",
               pulses, we_cnt, cur_player);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_column_fill();
    test_ignored_patterns();
    test_win();
    test_draw_and_new_game();
    test_win_on_last_move();
    test_new_game_in_write();
    test_async_reset_in_check();
    test_turn_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
